// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: machine width, instruction size, NOP
// encoding and the entry format handed from fetch to decode.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush. A push in a flush cycle lands in the
// freshly emptied queue, so a flush can be paired with a new first entry.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_head,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && (i_flush || !o_full);
  assign w_pop   = i_pop && !o_empty && !i_flush;

  // Pointer and occupancy update; flush empties, then takes an optional push
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= w_push ? ptr_inc('0) : '0;
      r_cnt <= w_push ? (AW+1)'(1) : '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage write; payload needs no reset since occupancy gates it
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[i_flush ? '0 : r_wr] <= i_push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues sequential word fetches, buffers
// responses and presents {pc, instr} to decode. A redirect flushes the buffer
// and marks every in-flight response for discard.
// Optional: FETCH_MISALIGN_TRAP_EN adds dec_misalign; a misaligned redirect
// then queues one NOP entry flagged misaligned and stalls fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        dec_misalign
`endif
);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_out, r_drop, w_out_nxt;
  logic            w_req_fire, w_rsp_fire, w_rsp_keep, w_trap, w_stall;
  logic [XLEN-1:0] w_redir_pc, w_tag_pc;
  fetch_entry_t    w_push_entry, w_head;
  logic [BAW:0]    w_buf_cnt;
  logic            w_buf_empty;
  logic            w_unused_buf_full;
  logic [TAW:0]    w_unused_tag_cnt;
  logic            w_unused_tag_empty, w_unused_tag_full;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. after reset) are ignored
  assign w_rsp_fire = imem_rsp_valid && (r_out != '0);
  assign w_out_nxt  = r_out + OW'(w_req_fire) - OW'(w_rsp_fire);
  assign w_rsp_keep = w_rsp_fire && (r_drop == '0) && !redirect_valid;

  // Credit rule: buffered + in-flight never exceed the buffer size
  assign imem_req_valid = i_rst && !w_stall &&
                          ((32'(r_out) + 32'(w_buf_cnt)) < 32'(FIFO_DEPTH)) &&
                          (32'(r_out) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr  = r_fetch_pc;

  always_comb begin
    w_push_entry = '{pc: w_tag_pc, instr: imem_rsp_data, misalign: 1'b0};
    if (w_trap) w_push_entry = '{pc: redirect_pc, instr: NOP_INSTR, misalign: 1'b1};
  end

  assign dec_valid = !w_buf_empty;
  assign dec_pc    = w_buf_empty ? '0 : w_head.pc;
  assign dec_instr = w_buf_empty ? '0 : w_head.instr;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_stall;
  assign w_trap       = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_stall      = r_stall;
  assign w_redir_pc   = redirect_pc;
  assign dec_misalign = !w_buf_empty && w_head.misalign;

  // Fetch halts after a trap redirect until an aligned redirect or reset
  always_ff @(posedge i_clk) begin
    if (!i_rst)              r_stall <= 1'b0;
    else if (redirect_valid) r_stall <= w_trap;
  end
`else
  logic w_unused_misc;
  assign w_trap        = 1'b0;
  assign w_stall       = 1'b0;
  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_misc = w_head.misalign ^ redirect_pc[1] ^ redirect_pc[0];
`endif

  // PC, in-flight count and discard count; a redirect resets discard to the
  // post-update in-flight count rather than adding to an older value
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_drop     <= w_out_nxt;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
        if (w_rsp_fire && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_rsp_keep || w_trap),
    .i_push_data (w_push_entry),
    .i_pop       (dec_valid && dec_ready),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_buf_cnt),
    .o_empty     (w_buf_empty),
    .o_full      (w_unused_buf_full)
  );

  // Tags follow every request, including ones later discarded, so they are
  // popped by every accepted response and never flushed by a redirect
  fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tagq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_req_fire),
    .i_push_data (imem_req_addr),
    .i_pop       (w_rsp_fire),
    .i_flush     (1'b0),
    .o_head      (w_tag_pc),
    .o_count     (w_unused_tag_cnt),
    .o_empty     (w_unused_tag_empty),
    .o_full      (w_unused_tag_full)
  );
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the architectural PC and issues sequential word fetches to instruction memory.
- Buffers returned instructions in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Consumes the jump stage's redirect (pc_update_control / pc_update_val). On redirect it flushes buffered and in-flight fetches so no wrong-path instruction reaches decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum memory requests in flight; ≤ FIFO_DEPTH.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-low.
- redirect_valid  input  1  from jump stage pc_update_control.
- redirect_pc  input  32  from jump stage pc_update_val.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; responses are in order and always accepted.
- imem_rsp_data  input  32  instruction word.
- dec_valid  output  1  instruction available to decode.
- dec_ready  input  1  decode accepts.
- dec_pc  output  32  PC of the presented instruction.
- dec_instr  output  32  presented instruction.

Behaviour:
- Reset (i_rst==0 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, dec_valid=0, dec_pc=0, dec_instr=0.
- Request issue:
  - imem_req_valid=1 when not in reset and (outstanding + fifo_count) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - imem_req_addr=fetch_pc.
  - On a request handshake: fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0); outstanding increments.
  - Request address and PC tag are pushed into an internal PC tag queue.
- Response:
  - On imem_rsp_valid, outstanding decrements.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {tag_pc, imem_rsp_data} is pushed into the FIFO. The credit rule guarantees the FIFO is never full at a push.
- Decode side:
  - dec_valid = FIFO not empty; dec_pc and dec_instr come from the FIFO head, zero when empty.
  - An entry pops on dec_valid && dec_ready.
  - Zero-cycle bypass from memory to decode is not allowed: minimum latency is response cycle + 1.
- Redirect (redirect_valid==1) has highest priority:
  - Next cycle: FIFO empty and fetch_pc=redirect_pc.
  - drop_cnt = outstanding after this cycle's request and response updates, so every in-flight response is discarded.
  - A request issued in the same cycle as a redirect counts as in flight and is dropped.
  - A dec pop in the redirect cycle still completes.
  - Back-to-back redirects: the later one wins; drop_cnt is recomputed each time, never summed with a stale value.
- Credit counters are sized for MAX_OUTSTANDING and must not overflow or underflow.
- Mid-operation reset discards everything. Any responses arriving after reset are ignored while outstanding==0.
- redirect_pc[1:0] is ignored for addressing; fetch_pc[1:0] is forced to 0 unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output dec_misalign (1 bit).
  - A redirect with redirect_pc[1:0]!=0 issues no memory request. Instead, exactly one FIFO entry {redirect_pc, 32'h0000_0013} is pushed with dec_misalign=1.
  - Fetch then stalls until the next redirect or reset.
- When undefined: the port is absent and low bits are cleared as above.

Decomposition:
- Shared processor package / defines: XLEN=32, INSTR_BYTES=4, NOP encoding 32'h0000_0013, fetch entry struct typedef {pc, instr, misalign}.
- One sub-module: fetch_fifo. Parameterized synchronous FIFO with push/pop/flush, count, empty/full, and synchronous active-low reset. It is instantiated twice: instruction buffer and PC tag queue.

Test Plan:
- Reset then memory with 1-cycle latency and dec_ready=1 → requests to 0x0, 0x4, 0x8 in successive cycles; dec_pc sequence 0x0, 0x4, 0x8 with matching data.
- dec_ready=0 for 10 cycles, FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; resumes one cycle after the first pop.
- Redirect to 0x100 with 3 requests in flight → those 3 responses dropped; next dec_pc=0x100; no stale PC ever valid.
- Redirect in the same cycle as a request handshake and a response → request dropped, response dropped, fetch_pc=0x200 next cycle.
- PC at 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → single dec entry pc=0x102, instr=0x13, dec_misalign=1; no imem request until the next redirect.
